// File: rtl/fifo_async_reader_if.sv
// Reader-side bus: the FIFO read port (rd_enable, r_empty, rdata, r_en) and the
// downstream valid/ready output port with the delivered-words counter.
// master = the reader block, slave = whoever sits around it (FIFO + consumer).
interface fifo_async_reader_if #(
    parameter int MEMORY_WIDTH = 4,
    parameter int COUNT_WIDTH  = 16
);
    logic                    rd_enable;
    logic                    r_empty;
    logic [MEMORY_WIDTH-1:0] rdata;
    logic                    r_en;
    logic [MEMORY_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [COUNT_WIDTH-1:0]  rd_count;

    modport master (
        input  rd_enable, r_empty, rdata, out_ready,
        output r_en, out_data, out_valid, rd_count
    );

    modport slave (
        output rd_enable, r_empty, rdata, out_ready,
        input  r_en, out_data, out_valid, rd_count
    );
endinterface

// File: rtl/fifo_async_reader.sv
// fifo_async_reader: drains the read side of a FIFO whose rdata arrives one
// cycle after r_en, into a 2-entry in-order skid buffer with valid/ready output.
// A read is only issued when the buffer is guaranteed to have room for it once
// it lands (occ + pend - pop < 2), so the buffer can never overflow.
// Optional feature: define FIFO_READER_COUNT_EN to build the rd_count counter
// (words delivered downstream, wrapping); otherwise rd_count is tied to 0.
module fifo_async_reader #(
    parameter int MEMORY_WIDTH = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                 r_clk,
    input  logic                 rrst_n,
    fifo_async_reader_if.master  bus
);

    logic [1:0]              occ_q, occ_d;
    logic                    pend_q, pend_d;
    logic [MEMORY_WIDTH-1:0] buf_q [2];
    logic [MEMORY_WIDTH-1:0] buf_d [2];
    logic                    pop;
    logic                    r_en_c;
    logic                    tail_sel;
    logic [1:0]              occ_after;

    // Handshake, read-issue decision and next-state of the skid buffer.
    always_comb begin
        pop       = (occ_q != 2'd0) & bus.out_ready;
        // occ + pend never exceeds 2 and pop implies occ >= 1, so 2 bits suffice.
        occ_after = occ_q + {1'b0, pend_q} - {1'b0, pop};
        r_en_c    = rrst_n & bus.rd_enable & ~bus.r_empty & (occ_after < 2'd2);
        pend_d    = r_en_c;
        occ_d     = occ_after;

        // Tail slot after any pop this cycle: index occ - pop.
        tail_sel  = (occ_q == 2'd2) | ((occ_q == 2'd1) & ~pop);

        buf_d[0]  = buf_q[0];
        buf_d[1]  = buf_q[1];
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        if (pend_q) begin
            if (tail_sel) begin
                buf_d[1] = bus.rdata;
            end else begin
                buf_d[0] = bus.rdata;
            end
        end
    end

    // Buffer state; reset discards in-flight and buffered words.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q    <= 2'd0;
            pend_q   <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            occ_q    <= occ_d;
            pend_q   <= pend_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
        end
    end

    assign bus.r_en      = r_en_c;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = buf_q[0];

`ifdef FIFO_READER_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    // Words delivered downstream; wraps naturally at 2^COUNT_WIDTH.
    always_comb begin
        cnt_d = cnt_q + {{(COUNT_WIDTH-1){1'b0}}, pop};
    end

    // Delivered-words counter register.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.rd_count = cnt_q;
`else
    assign bus.rd_count = {COUNT_WIDTH{1'b0}};
`endif

endmodule
